ds_addr_gen: RTL and testbench



---
 rtl/ds_addr_gen_pkg.sv | 21 ++
 rtl/ds_addr_gen_if.sv | 16 +
 rtl/ds_addr_gen_param_load.sv | 82 ++++++++
 rtl/ds_addr_gen.sv | 215 +++++++++++++++++++++
 tb/tb_ds_addr_gen.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ds_addr_gen_pkg.sv
// Shared definitions for the 2x2 downsampling address generator:
// default address width, constant-memory slot numbers, FSM states and
// the per-pixel item index type.
package ds_pkg;

  localparam int AW_DEF = 20;

  localparam logic [2:0] CM_SLOT_FIRST_SRC = 3'd3;
  localparam logic [2:0] CM_SLOT_FIRST_DST = 3'd4;
  localparam logic [2:0] CM_SLOT_LAST_SRC  = 3'd5;
  localparam logic [2:0] CM_SLOT_WIDTH     = 3'd6;

  typedef enum logic [1:0] {IDLE, LOAD, GEN, FIN} ds_state_t;

  // Item within one output pixel: 0..3 source taps, 4 destination.
  typedef logic [2:0] item_idx_t;

  localparam item_idx_t ITEM_P0  = 3'd0;
  localparam item_idx_t ITEM_DST = 3'd4;

endpackage

// File: rtl/ds_addr_gen_if.sv
// Valid/ready address channel from the address generator to the
// load/accumulate/store stage.
interface ds_addr_gen_if
  import ds_pkg::*;
#(
  parameter int AW = AW_DEF
);
  logic [AW-1:0] addr_out;
  logic          addr_dst;
  logic          addr_valid;
  logic          addr_ready;

  modport master (output addr_out, addr_dst, addr_valid, input addr_ready);
  modport slave  (input addr_out, addr_dst, addr_valid, output addr_ready);

endinterface

// File: rtl/ds_addr_gen_param_load.sv
// Parameter loader: issues the four constant-memory reads (src first,
// dst first, src last, width) on consecutive cycles and captures each
// word the cycle after its read. o_loaded is high in the cycle where the
// width word sits on the memory output; o_w forwards it that cycle so the
// parent can decide on the very edge that captures it.
module ds_param_load
  import ds_pkg::*;
#(
  parameter int         AW           = AW_DEF,
  parameter logic [2:0] CM_FIRST_SRC = CM_SLOT_FIRST_SRC,
  parameter logic [2:0] CM_FIRST_DST = CM_SLOT_FIRST_DST,
  parameter logic [2:0] CM_LAST_SRC  = CM_SLOT_LAST_SRC,
  parameter logic [2:0] CM_WIDTH     = CM_SLOT_WIDTH
)(
  input  logic          clock,
  input  logic          reset,
  input  logic          i_go,
  output logic          o_cm_r,
  output logic [2:0]    o_cm_addr,
  input  logic [AW-1:0] i_cm_out,
  output logic          o_loaded,
  output logic [AW-1:0] o_s,
  output logic [AW-1:0] o_d,
  output logic [AW-1:0] o_l,
  output logic [AW-1:0] o_w
);

  logic          r_run;
  logic [2:0]    r_step;
  logic          r_cm_r;
  logic [2:0]    r_cm_addr;
  logic [AW-1:0] r_s, r_d, r_l, r_w;

  // Read sequencer: step k drives slot k, reads stop after the width slot.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_run     <= 1'b0;
      r_step    <= 3'd0;
      r_cm_r    <= 1'b0;
      r_cm_addr <= 3'd0;
    end else if (i_go) begin
      r_run     <= 1'b1;
      r_step    <= 3'd0;
      r_cm_r    <= 1'b1;
      r_cm_addr <= CM_FIRST_SRC;
    end else if (r_run) begin
      r_step <= r_step + 3'd1;
      if (r_step == 3'd4) r_run <= 1'b0;
      case (r_step)
        3'd0:    r_cm_addr <= CM_FIRST_DST;
        3'd1:    r_cm_addr <= CM_LAST_SRC;
        3'd2:    r_cm_addr <= CM_WIDTH;
        default: begin
          r_cm_r    <= 1'b0;
          r_cm_addr <= 3'd0;
        end
      endcase
    end
  end

  // Capture each memory word one cycle after its read edge.
  always_ff @(posedge clock) begin
    if (r_run) begin
      case (r_step)
        3'd1:    r_s <= i_cm_out;
        3'd2:    r_d <= i_cm_out;
        3'd3:    r_l <= i_cm_out;
        3'd4:    r_w <= i_cm_out;
        default: ;
      endcase
    end
  end

  assign o_cm_r    = r_cm_r;
  assign o_cm_addr = r_cm_addr;
  assign o_loaded  = r_run && (r_step == 3'd4);
  assign o_s       = r_s;
  assign o_d       = r_d;
  assign o_l       = r_l;
  assign o_w       = o_loaded ? i_cm_out : r_w;

endmodule

// File: rtl/ds_addr_gen.sv
// 2x2 downsampling address generator. Loads S/D/L/W from the constant
// memory, then streams P, P+1, P+W, P+W+1 (source) and Q (destination)
// for every output pixel over a registered valid/ready channel.
// Optional feature macro: DS_PARAM_CHECK_EN (reject W=0, odd W or L<S
// with a sticky param_err instead of generating addresses).
module ds_addr_gen
  import ds_pkg::*;
#(
  parameter int         AW           = AW_DEF,
  parameter logic [2:0] CM_FIRST_SRC = CM_SLOT_FIRST_SRC,
  parameter logic [2:0] CM_FIRST_DST = CM_SLOT_FIRST_DST,
  parameter logic [2:0] CM_LAST_SRC  = CM_SLOT_LAST_SRC,
  parameter logic [2:0] CM_WIDTH     = CM_SLOT_WIDTH
)(
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          cm_r,
  output logic [2:0]    cm_addr,
  input  logic [AW-1:0] cm_out,
  output logic          param_err,
  ds_addr_gen_if.master addr_if
);

  localparam logic [AW-1:0] ONE   = AW'(1);
  localparam logic [AW-1:0] TWO   = AW'(2);
  localparam logic [AW:0]   FOUR  = (AW+1)'(4);
  localparam logic [AW+1:0] ONE_X = (AW+2)'(1);

  ds_state_t     r_state, w_state_nxt;
  logic          r_busy, r_done, r_valid, r_dst;
  logic [AW-1:0] r_addr;
  item_idx_t     r_idx;
  logic [AW-1:0] r_p, r_r, r_q, r_col;

  logic          w_go, w_loaded;
  logic [AW-1:0] w_s, w_d, w_l, w_w;
  logic          w_hs, w_last_item, w_wrap, w_row_over, w_end_run;
  logic          w_init_bad, w_param_bad;
  logic [AW:0]   w_col_end;
  logic [AW+1:0] w_r_nxt;
  logic [AW-1:0] w_p_nxt, w_item_nxt;
  item_idx_t     w_idx_inc;

  // True when a row pair starting at base cannot be read completely.
  // The extra headroom bits keep the sum exact, so any carry past the
  // address range compares as beyond the last source address.
  function automatic logic exceeds(input logic [AW+1:0] base,
                                   input logic [AW-1:0] w,
                                   input logic [AW-1:0] lim);
    logic [AW+1:0] last;
    last = base + {1'b0, w, 1'b0} - ONE_X;
    return (w < TWO) || (last > {2'b00, lim});
  endfunction

  // Address of item idx within the pixel whose block base is p.
  function automatic logic [AW-1:0] item_addr(input item_idx_t     idx,
                                              input logic [AW-1:0] p,
                                              input logic [AW-1:0] w,
                                              input logic [AW-1:0] q);
    case (idx)
      3'd0:    return p;
      3'd1:    return p + ONE;
      3'd2:    return p + w;
      3'd3:    return p + w + ONE;
      default: return q;
    endcase
  endfunction

  assign w_go = (r_state == IDLE) && start;

  ds_param_load #(
    .AW          (AW),
    .CM_FIRST_SRC(CM_FIRST_SRC),
    .CM_FIRST_DST(CM_FIRST_DST),
    .CM_LAST_SRC (CM_LAST_SRC),
    .CM_WIDTH    (CM_WIDTH)
  ) u_load (
    .clock    (clock),
    .reset    (reset),
    .i_go     (w_go),
    .o_cm_r   (cm_r),
    .o_cm_addr(cm_addr),
    .i_cm_out (cm_out),
    .o_loaded (w_loaded),
    .o_s      (w_s),
    .o_d      (w_d),
    .o_l      (w_l),
    .o_w      (w_w)
  );

  assign w_hs        = r_valid && addr_if.addr_ready;
  assign w_last_item = (r_idx == ITEM_DST);
  assign w_idx_inc   = r_idx + 3'd1;
  assign w_item_nxt  = item_addr(w_idx_inc, r_p, w_w, r_q);
  // Next block occupies columns col+2 and col+3; it must end inside the row.
  assign w_col_end   = {1'b0, r_col} + FOUR;
  assign w_wrap      = w_col_end > {1'b0, w_w};
  assign w_r_nxt     = {2'b00, r_r} + {1'b0, w_w, 1'b0};
  assign w_row_over  = exceeds(w_r_nxt, w_w, w_l);
  assign w_p_nxt     = w_wrap ? w_r_nxt[AW-1:0] : r_p + TWO;
  assign w_end_run   = (r_state == GEN) && w_hs && w_last_item && w_wrap && w_row_over;
  assign w_init_bad  = exceeds({2'b00, w_s}, w_w, w_l);

`ifdef DS_PARAM_CHECK_EN
  logic r_perr;

  assign w_param_bad = (w_w == '0) || w_w[0] || (w_l < w_s);

  // Sticky parameter error, cleared when the next run is accepted.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                          r_perr <= 1'b0;
    else if (w_go)                      r_perr <= 1'b0;
    else if ((r_state == LOAD) && w_loaded && w_param_bad) r_perr <= 1'b1;
  end

  assign param_err = r_perr;
`else
  assign w_param_bad = 1'b0;
  assign param_err   = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // FSM next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = LOAD;
      LOAD:    if (w_loaded) w_state_nxt = (w_param_bad || w_init_bad) ? FIN : GEN;
      GEN:     if (w_end_run) w_state_nxt = FIN;
      FIN:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Registered outputs: busy/done and the held address item.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_valid <= 1'b0;
      r_dst   <= 1'b0;
      r_addr  <= '0;
      r_idx   <= ITEM_P0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (start) r_busy <= 1'b1;
        LOAD: if (w_loaded) begin
          if (w_param_bad || w_init_bad) begin
            r_busy <= 1'b0;
            r_done <= 1'b1;
          end else begin
            r_valid <= 1'b1;
            r_dst   <= 1'b0;
            r_idx   <= ITEM_P0;
            r_addr  <= w_s;
          end
        end
        GEN: if (w_hs) begin
          if (w_end_run) begin
            r_valid <= 1'b0;
            r_dst   <= 1'b0;
            r_idx   <= ITEM_P0;
            r_addr  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else if (w_last_item) begin
            r_idx  <= ITEM_P0;
            r_dst  <= 1'b0;
            r_addr <= w_p_nxt;
          end else begin
            r_idx  <= w_idx_inc;
            r_dst  <= (w_idx_inc == ITEM_DST);
            r_addr <= w_item_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  // Block/row/destination pointers, stepped after each destination handshake.
  always_ff @(posedge clock) begin
    if ((r_state == LOAD) && w_loaded) begin
      r_p   <= w_s;
      r_r   <= w_s;
      r_q   <= w_d;
      r_col <= '0;
    end else if ((r_state == GEN) && w_hs && w_last_item) begin
      r_q <= r_q + ONE;
      r_p <= w_p_nxt;
      if (w_wrap) begin
        r_col <= '0;
        r_r   <= w_r_nxt[AW-1:0];
      end else begin
        r_col <= r_col + TWO;
      end
    end
  end

  assign busy               = r_busy;
  assign done               = r_done;
  assign addr_if.addr_out   = r_addr;
  assign addr_if.addr_dst   = r_dst;
  assign addr_if.addr_valid = r_valid;

endmodule

// File: tb/tb_ds_addr_gen.sv
// Bench for ds_addr_gen: constant-memory model, randomized ready and
// parameters, and an expected address list built directly from the
// row/column rules of the downsampler.
module tb_ds_addr_gen;

  localparam int AW = 20;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          busy, done, cm_r, param_err;
  logic [2:0]    cm_addr;
  logic [AW-1:0] cm_out;
  logic [AW-1:0] mem [0:7];

  int n_checks = 0;
  int n_errors = 0;

  logic [AW:0] exp_q [$];
  logic [AW:0] got_q [$];
  bit          exp_perr;

  ds_addr_gen_if #(.AW(AW)) aif ();

  ds_addr_gen #(.AW(AW)) dut (
    .clock    (clk),
    .reset    (rst),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .cm_r     (cm_r),
    .cm_addr  (cm_addr),
    .cm_out   (cm_out),
    .param_err(param_err),
    .addr_if  (aif)
  );

  always #5 clk = ~clk;

  // Constant memory: registered read, data valid the cycle after the read edge.
  always @(posedge clk) if (cm_r) cm_out <= mem[cm_addr];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [AW:0] it(input bit dst, input longint v);
    return {dst, v[AW-1:0]};
  endfunction

  // Expected stream: every complete 2x2 block, row pairs top to bottom.
  task automatic build_exp(input longint s, input longint d, input longint l, input longint w);
    longint q;
    exp_q.delete();
    exp_perr = 1'b0;
`ifdef DS_PARAM_CHECK_EN
    if (w == 0 || (w % 2) == 1 || l < s) begin
      exp_perr = 1'b1;
      return;
    end
`endif
    if (w < 2) return;
    q = d;
    for (longint r = s; r + 2*w - 1 <= l; r += 2*w) begin
      for (longint c = 0; c + 2 <= w; c += 2) begin
        exp_q.push_back(it(0, r + c));
        exp_q.push_back(it(0, r + c + 1));
        exp_q.push_back(it(0, r + c + w));
        exp_q.push_back(it(0, r + c + w + 1));
        exp_q.push_back(it(1, q));
        q++;
      end
    end
  endtask

  task automatic run_case(input string nm, input longint s, input longint d,
                          input longint l, input longint w, input int rdy_pct,
                          input int abort_at, input bit chk_t, input int ign_start_at);
    int          n_hs, n_done, nbad, nunst, budget, extra;
    bit          hold;
    logic [AW:0] held, cur, exp_it;
    mem[3] = s[AW-1:0];
    mem[4] = d[AW-1:0];
    mem[5] = l[AW-1:0];
    mem[6] = w[AW-1:0];
    build_exp(s, d, l, w);
    got_q.delete();
    n_hs = 0; n_done = 0; nbad = 0; nunst = 0; extra = 0;
    hold = 1'b0; held = '0;
    budget = exp_q.size() * 12 + 50;

    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (chk_t) begin
        if (k < 4) begin
          check({nm, "_cm_r"}, cm_r, 1);
          check({nm, "_cm_addr"}, cm_addr, 3 + k);
        end else begin
          check({nm, "_cm_r_off"}, cm_r, 0);
        end
        check({nm, "_valid_early"}, aif.addr_valid, 0);
        if (k == 0) check({nm, "_busy_rise"}, busy, 1);
      end
    end

    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      cur = {aif.addr_dst, aif.addr_out};
      if (chk_t && c == 0) check({nm, "_first_valid"}, aif.addr_valid, exp_q.size() != 0);
      if (hold && (!aif.addr_valid || cur !== held)) nunst++;
      if (done) begin
        n_done++;
        break;
      end
      if (ign_start_at > 0 && c == ign_start_at + 3) check({nm, "_busy_kept"}, busy, 1);
      start = (ign_start_at > 0 && c == ign_start_at);
      aif.addr_ready = ($urandom_range(0, 99) < rdy_pct);
      if (aif.addr_valid && aif.addr_ready) begin
        got_q.push_back(cur);
        exp_it = (n_hs < exp_q.size()) ? exp_q[n_hs] : 'x;
        if (cur !== exp_it) nbad++;
        if (nbad <= 3) check({nm, "_item"}, cur, exp_it);
        n_hs++;
      end
      hold = aif.addr_valid && !aif.addr_ready;
      held = cur;
      if (abort_at > 0 && n_hs == abort_at) begin
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check({nm, "_rst_busy"}, busy, 0);
        check({nm, "_rst_done"}, done, 0);
        check({nm, "_rst_valid"}, aif.addr_valid, 0);
        check({nm, "_rst_addr"}, aif.addr_out, 0);
        check({nm, "_rst_dst"}, aif.addr_dst, 0);
        check({nm, "_rst_cm_r"}, cm_r, 0);
        break;
      end
    end
    start = 1'b0;

    if (abort_at == 0) begin
      check({nm, "_done_seen"}, n_done, 1);
      check({nm, "_busy_fall"}, busy, 0);
      check({nm, "_n_items"}, got_q.size(), exp_q.size());
      check({nm, "_param_err"}, param_err, exp_perr);
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        if (done || busy || aif.addr_valid) extra++;
      end
      check({nm, "_quiet_after_done"}, extra, 0);
    end else begin
      check({nm, "_no_done"}, n_done, 0);
      check({nm, "_n_items"}, got_q.size(), abort_at);
    end
    check({nm, "_bad_items"}, nbad, 0);
    check({nm, "_unstable"}, nunst, 0);
    aif.addr_ready = 1'b1;
  endtask

  // Hand-derived points of the default 118-wide image.
  task automatic check_points(input string nm);
    int          pix [5];
    longint      val [5][5];
    int          nd;
    int          idx;
    logic [AW:0] g;
    pix = '{0, 1, 58, 59, 2064};
    val = '{'{0, 1, 118, 119, 10000},
            '{2, 3, 120, 121, 10001},
            '{116, 117, 234, 235, 10058},
            '{236, 237, 354, 355, 10059},
            '{8140, 8141, 8258, 8259, 12064}};
    for (int p = 0; p < 5; p++) begin
      for (int k = 0; k < 5; k++) begin
        idx = pix[p] * 5 + k;
        g = (idx < got_q.size()) ? got_q[idx] : '1;
        check($sformatf("%s_px%0d_%0d", nm, pix[p] + 1, k), g, it(k == 4, val[p][k]));
      end
    end
    nd = 0;
    foreach (got_q[i]) if (got_q[i][AW]) nd++;
    check({nm, "_n_dst"}, nd, 2065);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog time=%0t limit=3000000", $time);
    $fatal(1);
  end

  initial begin
    aif.addr_ready = 1'b1;
    for (int i = 0; i < 8; i++) mem[i] = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_cm_r", cm_r, 0);
    check("rst_cm_addr", cm_addr, 0);
    check("rst_valid", aif.addr_valid, 0);
    check("rst_dst", aif.addr_dst, 0);
    check("rst_addr", aif.addr_out, 0);
    check("rst_param_err", param_err, 0);
    rst = 1'b0;

    run_case("dflt", 0, 10000, 8259, 118, 100, 0, 1'b1, 100);
    check_points("dflt");

    run_case("bp", 0, 10000, 8259, 118, 30, 0, 1'b0, 0);
    check_points("bp");

    run_case("abort", 0, 10000, 8259, 118, 100, 37, 1'b0, 0);
    @(negedge clk);
    rst = 1'b0;

    run_case("restart", 0, 10000, 8259, 118, 100, 0, 1'b0, 0);
    check_points("restart");

    run_case("w3", 0, 500, 5, 3, 100, 0, 1'b0, 0);
`ifdef DS_PARAM_CHECK_EN
    check("w3_err_flag", param_err, 1);
`else
    check("w3_tap2", (got_q.size() > 2) ? got_q[2] : '1, it(0, 3));
`endif

    run_case("short", 0, 10000, 100, 118, 100, 0, 1'b0, 0);

    for (int t = 0; t < 8; t++) begin
      longint rs, rw, rr, rx, rl, rd;
      rs = $urandom_range(0, 1000);
      rw = $urandom_range(0, 20);
      rr = $urandom_range(0, 9);
      rx = $urandom_range(0, 20);
      if (rx > rw) rx = rw;
      rl = rs + rr * rw + rx - 1;
      if (rl < 0) rl = 0;
      rd = $urandom_range(0, (1 << AW) - 1);
      run_case($sformatf("rnd%0d", t), rs, rd, rl, rw, 50, 0, 1'b0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
